// File: rtl/ram2e_ufm_settings_log.sv
`default_nettype none
// ============================================================================
// Module   : ram2e_ufm_settings_log
// Desc     : NSET volatile 8-bit settings restored at power-up from an
//            append-only record log in the MAX II/V UFM sector. Commits append
//            one record; the sector is erased first once the log has wrapped.
// Revision : 1.0 - initial release
// ============================================================================
module ram2e_ufm_settings_log #(
    parameter int                NSET     = 2,
    parameter int                AW       = 9,
    parameter int                NREC     = 256,
    parameter logic [NSET*8-1:0] DEFAULTS = 16'h00FF,
    parameter logic [19:0]       TMO      = 20'hFFFFF
) (
    input  logic                    C14M,
    input  logic                    nRES,
    input  logic                    SetWr,
    input  logic [$clog2(NSET)-1:0] SetIdx,
    input  logic [7:0]              SetD,
    input  logic                    Commit,
    output logic [NSET*8-1:0]       Settings,
    output logic                    Ready,
    output logic                    ReqErase,
    output logic                    Err,
    output logic                    ARCLK,
    output logic                    ARShift,
    output logic                    ARDIn,
    output logic                    DRCLK,
    output logic                    DRShift,
    output logic                    DRDIn,
    output logic                    UFMErase,
    output logic                    UFMProgram,
    input  logic                    DRDOut,
    input  logic                    UFMBusy,
    input  logic                    RTPBusy
);

    localparam int NW = NSET / 2;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW = (NREC > 1) ? $clog2(NREC) : 1;

    typedef enum logic [3:0] {
        S_INIT_ADDR, S_INIT_LOAD, S_INIT_SHIFT, S_INIT_INC, S_INIT_CHECK,
        S_IDLE, S_ERASE, S_WR_ADDR, S_WR_DATA, S_WR_PROG
    } state_t;

    state_t            state_q, state_d;
    logic              ph_q, ph_d;
    logic              setup_q, setup_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        sub_q, sub_d;
    logic [19:0]       tmo_q, tmo_d;
    logic [WW-1:0]     w_q, w_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NSET*8-1:0] wbuf_q, wbuf_d, snap_q, snap_d, settings_q, settings_d;
    logic              reqerase_q, reqerase_d, err_q, err_d;
    logic [1:0]        bsync_q;
    logic              arclk_q, arclk_d, arshift_q, arshift_d, ardin_q, ardin_d;
    logic              drclk_q, drclk_d, drshift_q, drshift_d, drdin_q, drdin_d;
    logic              erase_q, erase_d, prog_q, prog_d;

    // Serial pulse engine controls for the current state
    logic              pulse_en, pulse_ar, pulse_shift, pulse_bit, pulse_done;
    logic [7:0]        pulse_n;
    logic              bsy;
    logic [AW-1:0]     w_addr, w_addr_sh;
    logic [15:0]       w_wrword, w_wrword_sh, w_rdword;

    assign bsy         = bsync_q[1];
    assign w_addr      = AW'(ptr_q) * AW'(NW) + AW'(w_q);
    assign w_addr_sh   = w_addr << cnt_q;
    assign w_wrword    = snap_q[32'(w_q)*16 +: 16];
    assign w_wrword_sh = w_wrword << cnt_q;
    assign w_rdword    = wbuf_q[32'(w_q)*16 +: 16];

    // Which serial clock the current state pulses, how often, and with what data
    always_comb begin
        pulse_en    = 1'b1;
        pulse_ar    = 1'b0;
        pulse_shift = 1'b1;
        pulse_bit   = 1'b0;
        pulse_n     = 8'd16;
        case (state_q)
            S_INIT_ADDR:  begin pulse_ar = 1'b1; pulse_n = 8'(AW); end
            S_INIT_LOAD:  begin pulse_shift = 1'b0; pulse_n = 8'd1; end
            S_INIT_SHIFT: ;
            S_INIT_INC:   begin pulse_ar = 1'b1; pulse_shift = 1'b0; pulse_n = 8'd1; end
            S_WR_ADDR:    begin pulse_ar = 1'b1; pulse_bit = w_addr_sh[AW-1]; pulse_n = 8'(AW); end
            S_WR_DATA:    pulse_bit = w_wrword_sh[15];
            default:      pulse_en = 1'b0;
        endcase
        pulse_done = pulse_en && ph_q && setup_q && (cnt_q == pulse_n - 8'd1);
    end

    // Next-state, serial pin sequencing and settings update
    always_comb begin
        state_d    = state_q;
        ph_d       = ~ph_q;
        setup_d    = 1'b0;
        cnt_d      = cnt_q;
        sub_d      = sub_q;
        tmo_d      = tmo_q;
        w_d        = w_q;
        ptr_d      = ptr_q;
        wbuf_d     = wbuf_q;
        snap_d     = snap_q;
        settings_d = settings_q;
        reqerase_d = reqerase_q;
        err_d      = err_q;
        arclk_d    = 1'b0;
        drclk_d    = 1'b0;
        arshift_d  = arshift_q;
        ardin_d    = ardin_q;
        drshift_d  = drshift_q;
        drdin_d    = drdin_q;
        erase_d    = 1'b0;
        prog_d     = 1'b0;

        // A pulse is a low/setup half followed by a high half; the high half
        // only follows a setup half, so entry on either phase is safe.
        if (pulse_en) begin
            if (!ph_q) begin
                setup_d = 1'b1;
                if (pulse_ar) begin arshift_d = pulse_shift; ardin_d = pulse_bit; end
                else          begin drshift_d = pulse_shift; drdin_d = pulse_bit; end
            end else if (setup_q) begin
                if (pulse_ar) arclk_d = 1'b1;
                else          drclk_d = 1'b1;
                cnt_d = cnt_q + 8'd1;
            end
        end

        case (state_q)
            S_INIT_ADDR: if (pulse_done) begin state_d = S_INIT_LOAD; cnt_d = '0; w_d = '0; end
            S_INIT_LOAD: if (pulse_done) begin state_d = S_INIT_SHIFT; cnt_d = '0; end
            S_INIT_SHIFT: begin
                // DRDOut has been stable since the previous DRCLK rise
                if (ph_q && setup_q) wbuf_d[32'(w_q)*16 +: 16] = {w_rdword[14:0], DRDOut};
                if (pulse_done) begin state_d = S_INIT_INC; cnt_d = '0; end
            end
            S_INIT_INC: if (pulse_done) begin
                cnt_d = '0;
                if (w_q == WW'(NW-1)) state_d = S_INIT_CHECK;
                else begin w_d = w_q + WW'(1); state_d = S_INIT_LOAD; end
            end
            S_INIT_CHECK: begin
                w_d = '0;
                if (wbuf_q == '1) state_d = S_IDLE;
                else begin
                    settings_d = wbuf_q;
                    if (ptr_q == PW'(NREC-1)) begin
                        reqerase_d = 1'b1; ptr_d = '0; state_d = S_IDLE;
                    end else begin
                        ptr_d = ptr_q + PW'(1); state_d = S_INIT_LOAD;
                    end
                end
            end
            S_IDLE: begin
                arshift_d = 1'b0; ardin_d = 1'b0; drshift_d = 1'b0; drdin_d = 1'b0;
                if (Commit && !bsy) begin
                    err_d   = 1'b0;
                    snap_d  = settings_q;
                    w_d     = '0;
                    cnt_d   = '0;
                    sub_d   = 2'd0;
                    state_d = reqerase_q ? S_ERASE : S_WR_ADDR;
                end
            end
            S_WR_ADDR: if (pulse_done) begin state_d = S_WR_DATA; cnt_d = '0; end
            S_WR_DATA: if (pulse_done) begin state_d = S_WR_PROG; cnt_d = '0; sub_d = 2'd0; end
            S_ERASE, S_WR_PROG: begin
                if (sub_q == 2'd0) begin
                    // Two-cycle start strobe, then wait for busy to rise and fall
                    if (state_q == S_ERASE) erase_d = 1'b1;
                    else                    prog_d  = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin sub_d = 2'd1; cnt_d = '0; tmo_d = '0; end
                end else begin
                    tmo_d = tmo_q + 20'd1;
                    if (tmo_q == TMO) begin
                        err_d = 1'b1; sub_d = 2'd0; state_d = S_IDLE;
                        arshift_d = 1'b0; ardin_d = 1'b0; drshift_d = 1'b0; drdin_d = 1'b0;
                    end else if (sub_q == 2'd1) begin
                        if (bsy) sub_d = 2'd2;
                    end else if (!bsy) begin
                        sub_d = 2'd0;
                        cnt_d = '0;
                        if (state_q == S_ERASE) begin
                            reqerase_d = 1'b0; ptr_d = '0; state_d = S_WR_ADDR;
                        end else if (w_q == WW'(NW-1)) begin
                            w_d = '0; state_d = S_IDLE;
                            if (ptr_q == PW'(NREC-1)) begin reqerase_d = 1'b1; ptr_d = '0; end
                            else ptr_d = ptr_q + PW'(1);
                        end else begin
                            w_d = w_q + WW'(1); state_d = S_WR_ADDR;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Host writes apply in every state and win over a record load
        if (SetWr) settings_d[32'(SetIdx)*8 +: 8] = SetD;
    end

    // State and output registers; busy is double-synchronised here
    always_ff @(posedge C14M or negedge nRES) begin
        if (!nRES) begin
            state_q <= S_INIT_ADDR; ph_q <= 1'b0; setup_q <= 1'b0; cnt_q <= '0;
            sub_q <= '0; tmo_q <= '0; w_q <= '0; ptr_q <= '0;
            wbuf_q <= '0; snap_q <= '0; settings_q <= DEFAULTS;
            reqerase_q <= 1'b0; err_q <= 1'b0; bsync_q <= '0;
            arclk_q <= 1'b0; arshift_q <= 1'b0; ardin_q <= 1'b0;
            drclk_q <= 1'b0; drshift_q <= 1'b0; drdin_q <= 1'b0;
            erase_q <= 1'b0; prog_q <= 1'b0;
        end else begin
            state_q <= state_d; ph_q <= ph_d; setup_q <= setup_d; cnt_q <= cnt_d;
            sub_q <= sub_d; tmo_q <= tmo_d; w_q <= w_d; ptr_q <= ptr_d;
            wbuf_q <= wbuf_d; snap_q <= snap_d; settings_q <= settings_d;
            reqerase_q <= reqerase_d; err_q <= err_d;
            bsync_q <= {bsync_q[0], UFMBusy | RTPBusy};
            arclk_q <= arclk_d; arshift_q <= arshift_d; ardin_q <= ardin_d;
            drclk_q <= drclk_d; drshift_q <= drshift_d; drdin_q <= drdin_d;
            erase_q <= erase_d; prog_q <= prog_d;
        end
    end

    assign Settings   = settings_q;
    assign Ready      = (state_q == S_IDLE);
    assign ReqErase   = reqerase_q;
    assign Err        = err_q;
    assign ARCLK      = arclk_q;
    assign ARShift    = arshift_q;
    assign ARDIn      = ardin_q;
    assign DRCLK      = drclk_q;
    assign DRShift    = drshift_q;
    assign DRDIn      = drdin_q;
    assign UFMErase   = erase_q;
    assign UFMProgram = prog_q;

endmodule
`default_nettype wire
